// File: rtl/mult_div_unit.sv
`default_nettype none
// ============================================================================
// Module : mult_div_unit
// Iterative HI/LO unit: shift-add multiplier and restoring divider (MIPS style).
// Rev    : 1.0  initial release
// ============================================================================
module mult_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_i,
  input  logic [1:0]       op_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             hi_we_i,
  input  logic             lo_we_i,
  input  logic [WIDTH-1:0] wdata_i,
  output logic             busy_o,
  output logic             done_o,
  output logic             div_by_zero_o,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o
);

  localparam int              c_CW       = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [c_CW-1:0] c_CNT_LAST = c_CW'(WIDTH - 1);

  localparam logic [1:0] c_IDLE = 2'd0;
  localparam logic [1:0] c_RUN  = 2'd1;
  localparam logic [1:0] c_FIX  = 2'd2;

  logic [1:0]         state_q, state_d;
  logic [c_CW-1:0]    cnt_q;
  logic               is_div_q;
  logic               neg_a_q;
  logic               neg_res_q;
  logic               bzero_q;
  logic [WIDTH-1:0]   opnd_q;
  logic [2*WIDTH-1:0] acc_q;
  logic [WIDTH-1:0]   hi_q, lo_q;
  logic               done_q, dbz_q;

  logic               w_sa, w_sb;
  logic [WIDTH-1:0]   w_amag, w_bmag;
  logic [WIDTH:0]     w_mul_sum;
  logic [WIDTH:0]     w_rem_sh;
  logic [WIDTH:0]     w_diff;
  logic [2*WIDTH-1:0] w_acc_step;
  logic [2*WIDTH-1:0] w_prod;
  logic [WIDTH-1:0]   w_quot_mag, w_rem_mag;
  logic [WIDTH-1:0]   w_quot, w_rem;
  logic [WIDTH-1:0]   w_hi_res, w_lo_res;

  // Operand conditioning: signed ops (op[0]==0) work on magnitudes.
  always_comb begin
    w_sa   = ~op_i[0] & a_i[WIDTH-1];
    w_sb   = ~op_i[0] & b_i[WIDTH-1];
    w_amag = w_sa ? -a_i : a_i;
    w_bmag = w_sb ? -b_i : b_i;
  end

  // One iteration. Multiply keeps {partial, multiplier} and shifts right;
  // divide keeps {remainder, dividend/quotient} and shifts left.
  always_comb begin
    w_mul_sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]} +
                (acc_q[0] ? {1'b0, opnd_q} : {(WIDTH+1){1'b0}});
    w_rem_sh  = acc_q[2*WIDTH-1:WIDTH-1];
    w_diff    = w_rem_sh - {1'b0, opnd_q};
    if (is_div_q) begin
      if (w_diff[WIDTH])
        w_acc_step = {w_rem_sh[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
      else
        w_acc_step = {w_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
    end else begin
      w_acc_step = {w_mul_sum, acc_q[WIDTH-1:1]};
    end
  end

  // With a zero divisor every step keeps rem_sh, so the remainder ends up as
  // |a|; the normal remainder sign fix then restores the raw dividend for HI.
  always_comb begin
    w_prod     = neg_res_q ? -acc_q : acc_q;
    w_quot_mag = acc_q[WIDTH-1:0];
    w_rem_mag  = acc_q[2*WIDTH-1:WIDTH];
    w_quot     = neg_res_q ? -w_quot_mag : w_quot_mag;
    w_rem      = neg_a_q ? -w_rem_mag : w_rem_mag;
    if (is_div_q) begin
      w_hi_res = w_rem;
      w_lo_res = bzero_q ? {WIDTH{1'b1}} : w_quot;
    end else begin
      w_hi_res = w_prod[2*WIDTH-1:WIDTH];
      w_lo_res = w_prod[WIDTH-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= c_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      c_IDLE:  if (start_i) state_d = c_RUN;
      c_RUN:   if (cnt_q == '0) state_d = c_FIX;
      c_FIX:   state_d = c_IDLE;
      default: state_d = c_IDLE;
    endcase
  end

  always_comb begin
    busy_o        = (state_q != c_IDLE);
    done_o        = done_q;
    div_by_zero_o = dbz_q;
    hi_o          = hi_q;
    lo_o          = lo_q;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q     <= '0;
      is_div_q  <= 1'b0;
      neg_a_q   <= 1'b0;
      neg_res_q <= 1'b0;
      bzero_q   <= 1'b0;
      opnd_q    <= '0;
      acc_q     <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      done_q    <= 1'b0;
      dbz_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      dbz_q  <= 1'b0;
      case (state_q)
        c_IDLE: begin
          if (start_i) begin
            cnt_q     <= c_CNT_LAST;
            is_div_q  <= op_i[1];
            neg_a_q   <= w_sa;
            neg_res_q <= w_sa ^ w_sb;
            bzero_q   <= (b_i == '0);
            opnd_q    <= op_i[1] ? w_bmag : w_amag;
            acc_q     <= {{WIDTH{1'b0}}, (op_i[1] ? w_amag : w_bmag)};
          end else begin
            if (hi_we_i) hi_q <= wdata_i;
            if (lo_we_i) lo_q <= wdata_i;
          end
        end
        c_RUN: begin
          acc_q <= w_acc_step;
          if (cnt_q != '0) cnt_q <= cnt_q - 1'b1;
        end
        c_FIX: begin
          hi_q   <= w_hi_res;
          lo_q   <= w_lo_res;
          done_q <= 1'b1;
          dbz_q  <= is_div_q & bzero_q;
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mult_div_unit.sv
`default_nettype none
// tb_mult_div_unit: vector table plus hand sequences; results are matched
// against a scoreboard queue filled when each operation is launched.
module tb_mult_div_unit;
  localparam int WIDTH = 32;
  localparam int LAT   = WIDTH + 1;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] a, b, wdata;
  logic             hi_we, lo_we;
  logic             busy_o, done_o, div_by_zero_o;
  logic [WIDTH-1:0] hi_o, lo_o;

  mult_div_unit #(.WIDTH(WIDTH)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .start_i       (start),
    .op_i          (op),
    .a_i           (a),
    .b_i           (b),
    .hi_we_i       (hi_we),
    .lo_we_i       (lo_we),
    .wdata_i       (wdata),
    .busy_o        (busy_o),
    .done_o        (done_o),
    .div_by_zero_o (div_by_zero_o),
    .hi_o          (hi_o),
    .lo_o          (lo_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dbz;
  } vec_t;

  vec_t vecs[$];
  vec_t sb_q[$];
  int   total = 0;
  int   bad   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic vec_t mk(input logic [1:0] o, input logic [31:0] va, input logic [31:0] vb,
                              input logic [31:0] eh, input logic [31:0] el, input logic ed);
    vec_t v;
    v.op = o; v.a = va; v.b = vb; v.hi = eh; v.lo = el; v.dbz = ed;
    return v;
  endfunction

  // Reference built from native 64-bit arithmetic.
  function automatic vec_t model(input logic [1:0] o, input logic [31:0] va, input logic [31:0] vb);
    vec_t        v;
    longint      sa, sb, p;
    logic [63:0] up;
    v.op = o; v.a = va; v.b = vb; v.dbz = 1'b0;
    case (o)
      2'b00: begin
        sa = longint'($signed(va));
        sb = longint'($signed(vb));
        p  = sa * sb;
        up = 64'(p);
        v.hi = up[63:32]; v.lo = up[31:0];
      end
      2'b01: begin
        up = {32'b0, va} * {32'b0, vb};
        v.hi = up[63:32]; v.lo = up[31:0];
      end
      default: begin
        if (vb == 32'd0) begin
          v.hi = va; v.lo = 32'hFFFF_FFFF; v.dbz = 1'b1;
        end else if (o == 2'b11) begin
          v.lo = va / vb; v.hi = va % vb;
        end else begin
          sa = longint'($signed(va));
          sb = longint'($signed(vb));
          v.lo = 32'(sa / sb); v.hi = 32'(sa % sb);
        end
      end
    endcase
    return v;
  endfunction

  task automatic launch(input vec_t v);
    op = v.op; a = v.a; b = v.b; start = 1'b1;
    sb_q.push_back(v);
    tick();
    start = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
    a = $urandom; b = $urandom;
  endtask

  task automatic wait_result(input string name, input int exp_lat);
    int   n       = 0;
    bit   seen    = 0;
    bit   busy_ok = 1;
    bit   dbz_ok  = 1;
    vec_t e;
    while (!seen && n < exp_lat + 10) begin
      tick();
      n++;
      if (done_o) seen = 1;
      else begin
        if (!busy_o) busy_ok = 0;
        if (div_by_zero_o) dbz_ok = 0;
      end
    end
    check({name, " latency"}, seen ? n : 0, exp_lat);
    check({name, " busy"}, {busy_ok, busy_o}, 2'b10);
    check({name, " dbz_early"}, dbz_ok, 1);
    check({name, " sb"}, sb_q.size(), 1);
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      check({name, " hi"}, hi_o, e.hi);
      check({name, " lo"}, lo_o, e.lo);
      check({name, " dbz"}, div_by_zero_o, e.dbz);
    end
    tick();
    check({name, " done_pulse"}, {done_o, div_by_zero_o, busy_o}, 3'b000);
  endtask

  initial begin
    logic [31:0] prev_hi;
    bit          spurious;
    logic [1:0]  rop;
    logic [31:0] ra, rb;

    rst_n = 1'b0; start = 1'b0; op = 2'b00; a = '0; b = '0;
    hi_we = 1'b0; lo_we = 1'b0; wdata = '0;

    vecs.push_back(mk(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0));
    vecs.push_back(mk(2'b00, 32'hFFFF_FFFD, 32'd5,         32'hFFFF_FFFF, 32'hFFFF_FFF1, 1'b0));
    vecs.push_back(mk(2'b00, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, 1'b0));
    vecs.push_back(mk(2'b00, 32'h7FFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h8000_0001, 1'b0));
    vecs.push_back(mk(2'b10, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0));
    vecs.push_back(mk(2'b10, 32'd7,         32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, 1'b0));
    vecs.push_back(mk(2'b11, 32'd7,         32'd2,         32'h0000_0001, 32'h0000_0003, 1'b0));
    vecs.push_back(mk(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 1'b0));
    vecs.push_back(mk(2'b11, 32'd100,       32'd0,         32'd100,       32'hFFFF_FFFF, 1'b1));
    vecs.push_back(mk(2'b10, 32'hFFFF_FFFB, 32'd0,         32'hFFFF_FFFB, 32'hFFFF_FFFF, 1'b1));
    vecs.push_back(mk(2'b11, 32'hFFFF_FFFF, 32'h10,        32'h0000_000F, 32'h0FFF_FFFF, 1'b0));
    for (int i = 0; i < 8; i++) begin
      rop = 2'($urandom_range(0, 3));
      ra  = $urandom;
      rb  = (i % 2 == 1) ? 32'($urandom_range(1, 1000)) : $urandom;
      vecs.push_back(model(rop, ra, rb));
    end

    tick(); tick();
    rst_n = 1'b1;
    check("reset hi",   hi_o, 32'd0);
    check("reset lo",   lo_o, 32'd0);
    check("reset ctrl", {busy_o, done_o, div_by_zero_o}, 3'b000);

    for (int i = 0; i < vecs.size(); i++) begin
      launch(vecs[i]);
      wait_result($sformatf("vec%0d", i), LAT);
    end

    // Requests during a run are ignored.
    prev_hi = hi_o;
    launch(mk(2'b01, 32'd6, 32'd7, 32'd0, 32'd42, 1'b0));
    for (int i = 0; i < 4; i++) tick();
    op = 2'b11; a = 32'd9; b = 32'd3; start = 1'b1; hi_we = 1'b1; wdata = 32'hDEAD;
    tick();
    start = 1'b0; hi_we = 1'b0;
    check("busy hi hold", hi_o, prev_hi);
    wait_result("ignored_req", LAT - 5);
    tick();
    check("no restart", busy_o, 1'b0);

    // Idle register writes.
    lo_we = 1'b1; wdata = 32'h1234;
    tick();
    lo_we = 1'b0;
    check("mtlo", lo_o, 32'h1234);
    hi_we = 1'b1; lo_we = 1'b1; wdata = 32'hAAAA_5555;
    tick();
    hi_we = 1'b0; lo_we = 1'b0;
    check("mthi_mtlo", {hi_o, lo_o}, {32'hAAAA_5555, 32'hAAAA_5555});

    // start beats a simultaneous HI write.
    hi_we = 1'b1; wdata = 32'h0000_BEEF;
    launch(mk(2'b01, 32'd2, 32'd3, 32'd0, 32'd6, 1'b0));
    check("start_we hi", hi_o, 32'hAAAA_5555);
    wait_result("start_we", LAT);

    // Reset mid-divide.
    hi_we = 1'b1; lo_we = 1'b1; wdata = 32'h5A5A_5A5A;
    tick();
    hi_we = 1'b0; lo_we = 1'b0;
    op = 2'b10; a = 32'hFFFF_FF9C; b = 32'd7; start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 9; i++) tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("abort hilo", {hi_o, lo_o}, 64'd0);
    check("abort busy", busy_o, 1'b0);
    spurious = 0;
    for (int i = 0; i < LAT + 5; i++) begin
      tick();
      if (done_o || div_by_zero_o || busy_o) spurious = 1;
    end
    check("abort no done", spurious, 1'b0);
    check("sb drained", sb_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
